factor_search: RTL and testbench

Inverse companion to the combinational factorizer. Given a divisor mask in the factorizer's bit encoding, this block scans candidate numbers 1..MAX_NUM in ascending order. It streams each number whose divisor set matches the mask over a valid/ready interface, then reports completion and the match count. Divisibility is tracked with incrementing residue counters, so no divider or modulo logic is used.

---
 rtl/factor_search_pkg.sv | 21 ++
 rtl/factor_search_divisor_residues.sv | 51 +++++
 rtl/factor_search.sv | 109 ++++++++++
 tb/tb_factor_search.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/factor_search_pkg.sv
// Shared definitions for factor_search: factor bit positions, FSM state codes,
// and factor-vector width.
package factor_search_pkg;

    localparam int FACTOR_W = 8;

    localparam int FACTOR_2 = 0;
    localparam int FACTOR_3 = 1;
    localparam int FACTOR_4 = 2;
    localparam int FACTOR_5 = 3;
    localparam int FACTOR_6 = 4;
    localparam int FACTOR_7 = 5;
    localparam int FACTOR_8 = 6;
    localparam int FACTOR_9 = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/factor_search_divisor_residues.sv
// divisor_residues: wrapping residue counters for 3/5/7/9 that track the current
// candidate, plus the combinational factor vector derived from them.
module divisor_residues
    import factor_search_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                step,
    input  logic [6:0]          n,
    output logic [FACTOR_W-1:0] factors
);

    logic [1:0] r3;
    logic [2:0] r5;
    logic [2:0] r7;
    logic [3:0] r9;

    // clear loads the residues of n=1, so step keeps them aligned with n+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r3 <= '0;
            r5 <= '0;
            r7 <= '0;
            r9 <= '0;
        end else if (clear) begin
            r3 <= 2'd1;
            r5 <= 3'd1;
            r7 <= 3'd1;
            r9 <= 4'd1;
        end else if (step) begin
            r3 <= (r3 == 2'd2) ? 2'd0 : r3 + 2'd1;
            r5 <= (r5 == 3'd4) ? 3'd0 : r5 + 3'd1;
            r7 <= (r7 == 3'd6) ? 3'd0 : r7 + 3'd1;
            r9 <= (r9 == 4'd8) ? 4'd0 : r9 + 4'd1;
        end
    end

    always_comb begin
        factors           = '0;
        factors[FACTOR_2] = ~n[0];
        factors[FACTOR_3] = (r3 == 2'd0);
        factors[FACTOR_4] = (n[1:0] == 2'b00);
        factors[FACTOR_5] = (r5 == 3'd0);
        factors[FACTOR_7] = (r7 == 3'd0);
        factors[FACTOR_8] = (n[2:0] == 3'b000);
        factors[FACTOR_9] = (r9 == 4'd0);
        factors[FACTOR_6] = factors[FACTOR_2] & factors[FACTOR_3];
    end

endmodule

// File: rtl/factor_search.sv
// factor_search: scans 1..MAX_NUM and streams numbers whose divisor set matches mask.
// Define FACTOR_SEARCH_EXACT_EN to enable the exact-match mode selected by the exact input.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | evaluating candidate n this cycle
// OUT   | presenting a match until out_ready
// DONE  | one-cycle completion pulse
module factor_search
    import factor_search_pkg::*;
#(
    parameter int MAX_NUM = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] mask,
    input  logic       exact,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] out_number,
    output logic       busy,
    output logic       done,
    output logic [7:0] count
);

    localparam logic [6:0] LAST = 7'(MAX_NUM);

    logic [1:0]          state;
    logic [6:0]          n;
    logic [7:0]          mask_q;
    logic [FACTOR_W-1:0] factors;
    logic                match;
    logic                last;
    logic                advance;

`ifdef FACTOR_SEARCH_EXACT_EN
    logic exact_q;

    always_ff @(posedge clk) begin
        if (rst) exact_q <= 1'b0;
        else if (state == ST_IDLE && start) exact_q <= exact;
    end

    assign match = exact_q ? (factors == mask_q) : ((factors & mask_q) == mask_q);
`else
    logic unused_exact;
    assign unused_exact = exact;
    assign match = ((factors & mask_q) == mask_q);
`endif

    assign last    = (n == LAST);
    assign advance = !last && ((state == ST_SCAN && !match) ||
                               (state == ST_OUT && out_ready));

    divisor_residues u_residues (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE && start),
        .step    (advance),
        .n       (n),
        .factors (factors)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            n          <= '0;
            mask_q     <= '0;
            out_number <= '0;
            count      <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    mask_q <= mask;
                    n      <= 7'd1;
                    count  <= '0;
                    state  <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (match) begin
                        out_number <= n;
                        state      <= ST_OUT;
                    end else if (last) begin
                        state <= ST_DONE;
                    end else begin
                        n <= n + 7'd1;
                    end
                end
                ST_OUT: if (out_ready) begin
                    count <= count + 8'd1;
                    if (last) begin
                        state <= ST_DONE;
                    end else begin
                        n     <= n + 7'd1;
                        state <= ST_SCAN;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (state == ST_OUT);
    assign busy      = (state == ST_SCAN) || (state == ST_OUT);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_factor_search.sv
// Scoreboard bench for factor_search: stimulus pushes expected numbers and counts,
// independent monitors pop and compare against two instances (MAX_NUM 127 and 12).
module tb_factor_search;
    import factor_search_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start12, exact, out_ready, out_ready12;
    logic [7:0] mask;
    logic       out_valid, busy, done, out_valid12, busy12, done12;
    logic [6:0] out_number, out_number12;
    logic [7:0] count, count12;

    factor_search #(.MAX_NUM(127)) dut (
        .clk(clk), .rst(rst), .start(start), .mask(mask), .exact(exact),
        .out_valid(out_valid), .out_ready(out_ready), .out_number(out_number),
        .busy(busy), .done(done), .count(count)
    );

    factor_search #(.MAX_NUM(12)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .mask(mask), .exact(exact),
        .out_valid(out_valid12), .out_ready(out_ready12), .out_number(out_number12),
        .busy(busy12), .done(done12), .count(count12)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_cnt_q[$];
    int q12[$];
    int cnt12_q[$];
    int dones = 0;
    int dones12 = 0;
    int cyc = 0;
    int hs12_cyc = -100;
    bit prev_done = 1'b0;
    bit prev_done12 = 1'b0;

    int primes_list[29] = '{1, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61,
                            67, 71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 121, 127};
    int mult21[6] = '{21, 42, 63, 84, 105, 126};
    int mult9sq[5] = '{9, 27, 81, 99, 117};

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic report(input string name);
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) report("unexpected_output");
                else check("out_number", out_number, exp_q.pop_front());
            end else if (out_valid && exp_q.size() > 0) begin
                check("held_number", out_number, exp_q[0]);
            end
            if (done) begin
                dones++;
                check("done_busy", busy, 0);
                check("done_single", prev_done, 0);
                check("missing_outputs", exp_q.size(), 0);
                if (exp_cnt_q.size() == 0) report("unexpected_done");
                else check("count", count, exp_cnt_q.pop_front());
            end
        end
        prev_done = done;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid12 && out_ready12) begin
                hs12_cyc = cyc;
                if (q12.size() == 0) report("unexpected_output12");
                else check("out_number12", out_number12, q12.pop_front());
            end
            if (done12) begin
                dones12++;
                check("done12_after_hs", cyc - hs12_cyc, 1);
                check("done12_single", prev_done12, 0);
                check("done12_busy", busy12, 0);
                if (cnt12_q.size() == 0) report("unexpected_done12");
                else check("count12", count12, cnt12_q.pop_front());
            end
        end
        prev_done12 = done12;
    end

    task automatic start_scan(input logic [7:0] m, input logic e);
        @(posedge clk); #1;
        start = 1'b1; mask = m; exact = e;
        @(posedge clk); #1;
        start = 1'b0; mask = 8'($urandom); exact = 1'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = dones;
        for (int i = 0; i < budget && dones == d0; i++) @(posedge clk);
        if (dones == d0) report("wait_done_timeout");
    endtask

    int expected_dones = 0;

    initial begin
        rst = 1'b1; start = 1'b0; start12 = 1'b0; mask = '0; exact = 1'b0;
        out_ready = 1'b1; out_ready12 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_number", out_number, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_state", dut.state, ST_IDLE);

        // evens
        for (int i = 1; i <= 63; i++) exp_q.push_back(2 * i);
        exp_cnt_q.push_back(63);
        start_scan(8'h01, 1'b0);
        wait_done(600); expected_dones++;

        // multiples of 21
        foreach (mult21[i]) exp_q.push_back(mult21[i]);
        exp_cnt_q.push_back(6);
        start_scan(8'h22, 1'b0);
        wait_done(600); expected_dones++;

`ifdef FACTOR_SEARCH_EXACT_EN
        foreach (mult9sq[i]) exp_q.push_back(mult9sq[i]);
        exp_cnt_q.push_back(5);
        start_scan(8'h82, 1'b1);
        wait_done(600); expected_dones++;

        foreach (primes_list[i]) exp_q.push_back(primes_list[i]);
        exp_cnt_q.push_back(29);
        start_scan(8'h00, 1'b1);
        wait_done(600); expected_dones++;

        exp_cnt_q.push_back(0);
        start_scan(8'h80, 1'b1);
        wait_done(600); expected_dones++;
`else
        // exact ignored: subset of {3,9} -> multiples of 9
        for (int i = 1; i <= 14; i++) exp_q.push_back(9 * i);
        exp_cnt_q.push_back(14);
        start_scan(8'h82, 1'b1);
        wait_done(600); expected_dones++;
`endif

        // backpressure on the first multiple of 8
        @(posedge clk); #1 out_ready = 1'b0;
        for (int i = 1; i <= 15; i++) exp_q.push_back(8 * i);
        exp_cnt_q.push_back(15);
        start_scan(8'h40, 1'b0);
        for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
        check("bp_valid_seen", out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_number", out_number, 8);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(600); expected_dones++;

        // start while busy is ignored
        foreach (mult21[i]) exp_q.push_back(mult21[i]);
        exp_cnt_q.push_back(6);
        start_scan(8'h22, 1'b0);
        repeat (30) @(posedge clk);
        #1 start = 1'b1; mask = 8'h01;
        @(posedge clk); #1 start = 1'b0;
        wait_done(600); expected_dones++;

        // reset mid-stream
        for (int i = 1; i <= 63; i++) exp_q.push_back(2 * i);
        exp_cnt_q.push_back(63);
        start_scan(8'h01, 1'b0);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_number", out_number, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_state", dut.state, ST_IDLE);
        exp_q.delete();
        exp_cnt_q.delete();

        foreach (mult21[i]) exp_q.push_back(mult21[i]);
        exp_cnt_q.push_back(6);
        start_scan(8'h22, 1'b0);
        wait_done(600); expected_dones++;

        // MAX_NUM = 12 instance
        q12.push_back(4); q12.push_back(8); q12.push_back(12);
        cnt12_q.push_back(3);
        @(posedge clk); #1 start12 = 1'b1; mask = 8'h04; exact = 1'b0;
        @(posedge clk); #1 start12 = 1'b0;
        for (int i = 0; i < 100 && dones12 == 0; i++) @(posedge clk);
        check("dones12", dones12, 1);
        check("q12_drained", q12.size(), 0);

        repeat (3) @(posedge clk);
        check("total_dones", dones, expected_dones);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
